// File: rtl/signal_decoder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | signal_decoder_pkg : shared frame-format constants and helpers   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package signal_decoder_pkg;

   localparam int c_WIDTH = 8;
   localparam int c_T2    = 2;

   // Generator and decoder both derive bit length and sample point from these.
   function automatic int sd_bit_cyc(input int t2);
      return t2 + 1;
   endfunction

   function automatic int sd_sample_off(input int t2);
      return 1 + t2 / 2;
   endfunction

   localparam int c_BIT_CYC    = sd_bit_cyc(c_T2);
   localparam int c_SAMPLE_OFF = sd_sample_off(c_T2);

endpackage
`default_nettype wire

// File: rtl/frame_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | frame_timer : period counter, wrap detect and frame-edge strobe  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module frame_timer
   import signal_decoder_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_frame_start,
   input  logic [31:0] i_t1,
   output logic        o_frame_edge,
   output logic        o_wrap,
   output logic [31:0] o_period
);

   logic        r_started;
   logic [31:0] r_count;
   logic [31:0] r_period;
   logic        w_wrap;
   logic        w_frame_edge;

   // The first edge out of reset opens a frame without touching the counter.
   assign w_wrap       = r_started && (r_count == r_period);
   assign w_frame_edge = !r_started || w_wrap || i_frame_start;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_started <= 1'b0;
         r_count   <= '0;
         r_period  <= '0;
      end else begin
         r_started <= 1'b1;
         if (w_frame_edge) begin
            r_count  <= '0;
            r_period <= i_t1;
         end else begin
            r_count  <= r_count + 32'd1;
         end
      end
   end

   assign o_frame_edge = w_frame_edge;
   assign o_wrap       = w_wrap;
   assign o_period     = r_period;

endmodule
`default_nettype wire

// File: rtl/signal_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | signal_decoder : frame-synchronous serial word decoder (LSB 1st) |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module signal_decoder
   import signal_decoder_pkg::*;
#(
   parameter int WIDTH = c_WIDTH,
   parameter int T2    = c_T2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             signal_in,
   input  logic [31:0]      T1,
   input  logic             frame_start,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             frame_err,
   output logic             busy
);

   localparam int c_BIT_LEN    = sd_bit_cyc(T2);
   localparam int c_FIRST_WAIT = sd_sample_off(T2);
   localparam int c_WAIT_W     = $clog2(c_BIT_LEN + 1);
   localparam int c_IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int c_MIN_PERIOD = WIDTH * c_BIT_LEN;

   logic                r_busy;
   logic [c_WAIT_W-1:0] r_wait;
   logic [c_IDX_W-1:0]  r_idx;
   logic [WIDTH-1:0]    r_shift;
   logic [WIDTH-1:0]    r_data;
   logic                r_valid;
   logic                r_err;

   logic                w_frame_edge;
   logic                w_wrap;
   logic [31:0]         w_period;
   logic                w_short;
   logic                w_sample;
   logic                w_last;
   logic                w_err;
   logic [WIDTH-1:0]    w_word;

   frame_timer u_frame_timer (
      .clk           (clk),
      .reset         (reset),
      .i_frame_start (frame_start),
      .i_t1          (T1),
      .o_frame_edge  (w_frame_edge),
      .o_wrap        (w_wrap),
      .o_period      (w_period)
   );

   // A period too short to carry a whole word is flagged at every wrap.
   assign w_short  = (w_period < 32'(c_MIN_PERIOD));
   assign w_sample = r_busy && !w_frame_edge && (r_wait == c_WAIT_W'(1));
   assign w_last   = (r_idx == c_IDX_W'(WIDTH - 1));
   assign w_word   = r_shift | (WIDTH'(signal_in) << r_idx);
   assign w_err    = (frame_start & r_busy & ~w_wrap) | (w_wrap & w_short);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy  <= 1'b0;
         r_wait  <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         if (w_frame_edge) begin
            r_err   <= w_err;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_wait  <= c_WAIT_W'(c_FIRST_WAIT);
            r_shift <= '0;
         end else if (w_sample) begin
            r_shift <= w_word;
            r_wait  <= c_WAIT_W'(c_BIT_LEN);
            if (w_last) begin
               r_busy <= 1'b0;
               if (!w_short) begin
                  r_data  <= w_word;
                  r_valid <= 1'b1;
               end
            end else begin
               r_idx <= r_idx + c_IDX_W'(1);
            end
         end else if (r_busy) begin
            r_wait <= r_wait - c_WAIT_W'(1);
         end
      end
   end

   assign data_out   = r_data;
   assign data_valid = r_valid;
   assign frame_err  = r_err;
   assign busy       = r_busy;

endmodule
`default_nettype wire
